// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// flush/stall/bubble control and a saturating backpressure counter.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    NOP_VALUE = DATA_W'(32'h0000_0013),
  parameter bit                   SKID      = 1'b1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              room;
  logic              acc;
  logic              drn;

  // With a skid entry, readiness only looks at registered state, cutting the
  // combinational out_ready_i -> in_ready_o path.
  assign room        = SKID ? ~s_valid : (~m_valid | out_ready_i);
  assign in_ready_o  = ~stall_i & ~flush_i & ~bubble_i & room;
  assign out_valid_o = m_valid & ~stall_i & ~flush_i;
  assign acc         = in_valid_i & in_ready_o;
  assign drn         = out_valid_o & out_ready_i;
  assign out_data_o  = m_data;
  assign occupancy_o = 2'(m_valid) + 2'(s_valid);

  // Stall needs no branch of its own: it forces acc and drn low, so every
  // entry simply holds.
  always_ff @(posedge clk_i) begin
    // NOTE: payload registers are reset too, so an empty stage drives NOP_VALUE
    // rather than stale or X data into the next stage.
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= NOP_VALUE;
      s_valid <= 1'b0;
      s_data  <= NOP_VALUE;
    end else if (flush_i) begin
      m_valid <= 1'b0;
      m_data  <= NOP_VALUE;
      s_valid <= 1'b0;
      s_data  <= NOP_VALUE;
    end else if (SKID) begin
      if (drn && s_valid) begin
        // In-ready is low while S is full, so no accept competes here.
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= 1'b0;
        s_data  <= NOP_VALUE;
      end else if (acc && (!m_valid || drn)) begin
        m_valid <= 1'b1;
        m_data  <= in_data_i;
      end else if (acc) begin
        s_valid <= 1'b1;
        s_data  <= in_data_i;
      end else if (drn) begin
        m_valid <= 1'b0;
        m_data  <= NOP_VALUE;
      end
    end else begin
      if (acc) begin
        m_valid <= 1'b1;
        m_data  <= in_data_i;
      end else if (drn) begin
        m_valid <= 1'b0;
        m_data  <= NOP_VALUE;
      end
    end
  end

  // Counts stalled-by-downstream cycles; flush never reaches it because
  // out_valid_o is masked during the flush cycle.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      bp_cnt_o <= '0;
    end else if (out_valid_o && !out_ready_i && (bp_cnt_o != '1)) begin
      bp_cnt_o <= bp_cnt_o + CNT_W'(1);
    end
  end

endmodule
